// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache lookup/refill controller: tag_mem read, tag compare against per-line valid bits,
// line fetch on miss, tag refill, saturating hit/miss counters and deferred whole-cache flush.
module dm_cache_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int OFFSET_LENGTH = 2,
  parameter int INDEX_LENGTH  = 8,
  parameter int TAG_LENGTH    = ADDR_WIDTH - INDEX_LENGTH - OFFSET_LENGTH,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  output logic                    cpu_resp_valid,
  output logic                    cpu_resp_hit,
  input  logic                    flush,
  output logic                    tm_write,
  output logic [INDEX_LENGTH-1:0] tm_index,
  output logic [TAG_LENGTH-1:0]   tm_tag_in,
  input  logic [TAG_LENGTH-1:0]   tm_tag_out,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_resp_valid,
  output logic [CNT_WIDTH-1:0]    hit_cnt,
  output logic [CNT_WIDTH-1:0]    miss_cnt
);

  localparam int NUM_CACHE_LINES = 2 ** INDEX_LENGTH;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] CMP   = 3'd2;
  localparam logic [2:0] MREQ  = 3'd3;
  localparam logic [2:0] MWAIT = 3'd4;
  localparam logic [2:0] FILL  = 3'd5;
  localparam logic [2:0] RESP  = 3'd6;

  logic [2:0]                 state_q, state_d;
  logic [TAG_LENGTH-1:0]      tag_q, tag_d;
  logic [INDEX_LENGTH-1:0]    index_q, index_d;
  logic [NUM_CACHE_LINES-1:0] valid_q, valid_d;
  logic                       flush_pending_q, flush_pending_d;
  logic                       resp_hit_q, resp_hit_d;
  logic [CNT_WIDTH-1:0]       hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]       miss_cnt_q, miss_cnt_d;
  logic                       lookup_hit;
  logic                       accept;

  // Byte-offset bits never influence a line lookup.
  logic unused_offset;
  assign unused_offset = ^cpu_addr[OFFSET_LENGTH-1:0];

  assign lookup_hit = valid_q[index_q] && (tm_tag_out == tag_q);

  // A flush seen in IDLE is applied on the same edge that accepts a request, so the
  // accepted lookup already observes the cleared valid bits; only a pending flush blocks.
  assign accept = (state_q == IDLE) && !flush_pending_q && cpu_req_valid;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through the case infers a latch.
    state_d         = state_q;
    tag_d           = tag_q;
    index_d         = index_q;
    valid_d         = valid_q;
    flush_pending_d = flush_pending_q | flush;
    resp_hit_d      = resp_hit_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (flush || flush_pending_q) begin
          valid_d         = '0;
          flush_pending_d = 1'b0;
        end
        if (accept) begin
          tag_d   = cpu_addr[ADDR_WIDTH-1 -: TAG_LENGTH];
          index_d = cpu_addr[OFFSET_LENGTH +: INDEX_LENGTH];
          state_d = READ;
        end
      end
      READ: state_d = CMP;
      CMP: begin
        if (lookup_hit) begin
          if (~&hit_cnt_q) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
          resp_hit_d = 1'b1;
          state_d    = RESP;
        end else begin
          if (~&miss_cnt_q) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
          state_d = MREQ;
        end
      end
      MREQ:  if (mem_req_ready) state_d = MWAIT;
      MWAIT: if (mem_resp_valid) state_d = FILL;
      FILL: begin
        valid_d[index_q] = 1'b1;
        state_d          = RESP;
      end
      RESP: begin
        resp_hit_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: valid bits live in flops rather than RAM so reset and flush can clear all lines at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      tag_q           <= '0;
      index_q         <= '0;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      resp_hit_q      <= 1'b0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q         <= state_d;
      tag_q           <= tag_d;
      index_q         <= index_d;
      valid_q         <= valid_d;
      flush_pending_q <= flush_pending_d;
      resp_hit_q      <= resp_hit_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
    end
  end

  assign cpu_req_ready  = (state_q == IDLE) && !flush_pending_q;
  assign cpu_resp_valid = (state_q == RESP);
  assign cpu_resp_hit   = resp_hit_q;
  assign tm_write       = (state_q == FILL);
  assign tm_index       = index_q;
  assign tm_tag_in      = tag_q;
  assign mem_req_valid  = (state_q == MREQ);
  assign mem_req_addr   = {tag_q, index_q, {OFFSET_LENGTH{1'b0}}};
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: tag_mem and memory responders plus a line-level
// reference model (valid/tag arrays and request counts) driven by directed and random traffic.
module tb_dm_cache_ctrl;

  localparam int AW = 32;
  localparam int OL = 2;
  localparam int IL = 8;
  localparam int TL = 22;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req_valid, cpu_req_ready;
  logic [AW-1:0] cpu_addr;
  logic          cpu_resp_valid, cpu_resp_hit;
  logic          flush;
  logic          tm_write;
  logic [IL-1:0] tm_index;
  logic [TL-1:0] tm_tag_in, tm_tag_out;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_resp_valid;
  logic [CW-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dm_cache_ctrl #(
    .ADDR_WIDTH(AW), .OFFSET_LENGTH(OL), .INDEX_LENGTH(IL), .TAG_LENGTH(TL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit), .flush(flush),
    .tm_write(tm_write), .tm_index(tm_index), .tm_tag_in(tm_tag_in), .tm_tag_out(tm_tag_out),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // tag_mem: synchronous write, one-cycle registered read
  logic [TL-1:0] tmem [256];
  always @(posedge clk) begin
    if (tm_write === 1'b1) tmem[tm_index] <= tm_tag_in;
    tm_tag_out <= tmem[tm_index];
  end

  // Reference model: which lines hold which tag, and how many hits/misses were served
  bit            ref_valid [256];
  logic [TL-1:0] ref_tag   [256];
  int            ref_hits, ref_misses;
  logic [AW-1:0] last_fill_addr;
  int            n_checks, n_fail;

  function automatic void model_flush();
    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
  endfunction

  function automatic void model_reset();
    model_flush();
    ref_hits   = 0;
    ref_misses = 0;
  endfunction

  function automatic logic [CW-1:0] sat(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  task automatic start_req(input logic [AW-1:0] addr, output bit ok);
    int w = 0;
    while (cpu_req_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    n_checks++;
    if (cpu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_wait: ready=%b after %0d cycles, required 1", cpu_req_ready, w);
      ok = 1'b0;
      return;
    end
    cpu_req_valid = 1'b1;
    cpu_addr      = addr;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    cpu_addr      = $urandom;
    ok            = 1'b1;
    n_checks++;
    if (cpu_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: ready=%b while busy, required 0", cpu_req_ready);
    end
  endtask

  // One complete request with a scripted memory: stall = cycles mem_req_ready stays low,
  // rdelay = MWAIT cycles before the response, spurious = early mem_resp_valid in MREQ,
  // flush_mid = flush pulse in the first MWAIT cycle.
  task automatic run_req(input logic [AW-1:0] addr, input int stall, input int rdelay,
                         input bit spurious, input bit flush_mid, output logic got_hit,
                         output logic [AW-1:0] got_maddr, output logic [IL-1:0] got_idx,
                         output logic [TL-1:0] got_tag);
    logic [TL-1:0] exp_tag;
    logic [IL-1:0] exp_idx;
    logic [AW-1:0] exp_maddr;
    bit exp_hit, ok, done, handshake, resp_given, flushed;
    int cyc, reqs, fills, wait_cnt;
    exp_tag   = TL'(addr >> (OL + IL));
    exp_idx   = IL'((addr >> OL) % 256);
    exp_maddr = (addr / 4) * 4;
    exp_hit   = ref_valid[exp_idx] && (ref_tag[exp_idx] == exp_tag);
    got_hit = 1'bx; got_maddr = '0; got_idx = '0; got_tag = '0;
    done = 0; handshake = 0; resp_given = 0; flushed = 0;
    reqs = 0; fills = 0; wait_cnt = 0;
    start_req(addr, ok);
    if (!ok) return;
    cyc = 1;
    while (!done && cyc < 80) begin
      @(posedge clk); #1; cyc++;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; flush = 1'b0;
      if (cpu_resp_valid === 1'b1) done = 1;
      else begin
        if (tm_write === 1'b1) begin
          fills++; got_idx = tm_index; got_tag = tm_tag_in;
          n_checks++;
          if (!resp_given) begin
            n_fail++;
            $display("FAIL early_fill: tm_write=1 at cycle %0d before memory response", cyc);
          end
        end
        if (mem_req_valid === 1'b1) begin
          reqs++; got_maddr = mem_req_addr;
          n_checks++;
          if (mem_req_addr !== exp_maddr) begin
            n_fail++;
            $display("FAIL mem_req_addr: got %h, required %h", mem_req_addr, exp_maddr);
          end
          if (reqs > stall) begin mem_req_ready = 1'b1; handshake = 1; end
          if (spurious && reqs == 1) mem_resp_valid = 1'b1;
        end else if (handshake && !resp_given) begin
          wait_cnt++;
          if (flush_mid && wait_cnt == 1) begin flush = 1'b1; flushed = 1; end
          if (wait_cnt > rdelay) begin mem_resp_valid = 1'b1; resp_given = 1; end
        end
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL resp_timeout: no cpu_resp_valid for addr %h within %0d cycles", addr, cyc);
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; flush = 1'b0;
      model_reset();
      return;
    end
    got_hit = cpu_resp_hit;
    if (exp_hit) ref_hits++; else ref_misses++;
    n_checks++;
    if (cpu_resp_hit !== exp_hit) begin
      n_fail++;
      $display("FAIL resp_hit: addr %h got %b, required %b", addr, cpu_resp_hit, exp_hit);
    end
    n_checks++;
    if (exp_hit && (cyc !== 3 || reqs !== 0 || fills !== 0)) begin
      n_fail++;
      $display("FAIL hit_path: latency %0d reqs %0d fills %0d, required 3/0/0", cyc, reqs, fills);
    end else if (!exp_hit && (reqs !== stall + 1 || fills !== 1)) begin
      n_fail++;
      $display("FAIL miss_path: reqs %0d fills %0d, required %0d/1", reqs, fills, stall + 1);
    end
    if (!exp_hit) begin
      n_checks++;
      if (got_idx !== exp_idx || got_tag !== exp_tag) begin
        n_fail++;
        $display("FAIL fill_data: idx %h tag %h, required %h %h", got_idx, got_tag, exp_idx, exp_tag);
      end
      ref_valid[exp_idx] = 1'b1;
      ref_tag[exp_idx]   = exp_tag;
      last_fill_addr     = addr;
    end
    n_checks++;
    if (hit_cnt !== sat(ref_hits) || miss_cnt !== sat(ref_misses)) begin
      n_fail++;
      $display("FAIL counters: hit %0d miss %0d, required %0d %0d", hit_cnt, miss_cnt,
               sat(ref_hits), sat(ref_misses));
    end
    @(posedge clk); #1;
    n_checks++;
    if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== !flushed) begin
      n_fail++;
      $display("FAIL post_resp: resp_valid %b ready %b, required 0 %b", cpu_resp_valid,
               cpu_req_ready, !flushed);
    end
    if (flushed) model_flush();
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
    n_checks++;
    if (cpu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_flush_ready: ready=%b, required 1", cpu_req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req_valid = 1'b0; cpu_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({cpu_req_ready, cpu_resp_valid, cpu_resp_hit, tm_write, mem_req_valid} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/rv/rh/tw/mv=%b, required 10000",
               {cpu_req_ready, cpu_resp_valid, cpu_resp_hit, tm_write, mem_req_valid});
    end
    n_checks++;
    if (tm_index !== '0 || tm_tag_in !== '0 || mem_req_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_data: idx %h tag %h maddr %h, required 0", tm_index, tm_tag_in, mem_req_addr);
    end
    n_checks++;
    if (hit_cnt !== '0 || miss_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: hit %0d miss %0d, required 0 0", hit_cnt, miss_cnt);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (cpu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: ready=%b, required 1", cpu_req_ready);
    end
    model_reset();
  endtask

  task automatic test_miss_hit_conflict();
    logic h; logic [AW-1:0] ma; logic [IL-1:0] ix; logic [TL-1:0] tg;
    run_req(32'h0000_1236, 0, 1, 0, 0, h, ma, ix, tg);
    n_checks++;
    if (h !== 1'b0 || ma !== 32'h0000_1234 || ix !== 8'h8D || tg !== 22'h4 || miss_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL first_miss: hit %b maddr %h idx %h tag %h miss_cnt %0d, required 0 1234 8d 4 1",
               h, ma, ix, tg, miss_cnt);
    end
    run_req(32'h0000_1236, 0, 0, 0, 0, h, ma, ix, tg);
    n_checks++;
    if (h !== 1'b1 || hit_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL repeat_hit: hit %b hit_cnt %0d, required 1 1", h, hit_cnt);
    end
    run_req(32'h0000_1636, 1, 0, 0, 0, h, ma, ix, tg);
    n_checks++;
    if (h !== 1'b0 || ix !== 8'h8D || tg !== 22'h5) begin
      n_fail++;
      $display("FAIL conflict: hit %b idx %h tag %h, required 0 8d 5", h, ix, tg);
    end
    run_req(32'h0000_1236, 0, 2, 0, 0, h, ma, ix, tg);
    n_checks++;
    if (h !== 1'b0) begin
      n_fail++;
      $display("FAIL evicted: hit %b, required 0", h);
    end
  endtask

  task automatic test_flush_in_mwait();
    logic h; logic [AW-1:0] ma; logic [IL-1:0] ix; logic [TL-1:0] tg;
    run_req(32'h0000_1636, 0, 2, 0, 1, h, ma, ix, tg);
    run_req(32'h0000_1636, 0, 0, 0, 0, h, ma, ix, tg);
    n_checks++;
    if (h !== 1'b0) begin
      n_fail++;
      $display("FAIL flushed_line: hit %b, required 0", h);
    end
    flush_idle();
    run_req(32'h0000_1636, 0, 0, 0, 0, h, ma, ix, tg);
  endtask

  task automatic test_mem_stall();
    logic h; logic [AW-1:0] ma; logic [IL-1:0] ix; logic [TL-1:0] tg;
    run_req(32'hCAFE_0C41, 5, 2, 1, 0, h, ma, ix, tg);
    n_checks++;
    if (h !== 1'b0 || ma !== 32'hCAFE_0C40) begin
      n_fail++;
      $display("FAIL stall_miss: hit %b maddr %h, required 0 cafe0c40", h, ma);
    end
    run_req(32'hCAFE_0C43, 0, 0, 0, 0, h, ma, ix, tg);
  endtask

  task automatic test_random();
    logic h; logic [AW-1:0] ma; logic [IL-1:0] ix; logic [TL-1:0] tg;
    logic [AW-1:0] addr;
    for (int n = 0; n < 150; n++) begin
      addr = (AW'($urandom_range(0, 2) + 22'h1F0) << (OL + IL))
           | (AW'($urandom_range(0, 3) * 37) << OL) | AW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) flush_idle();
      run_req(addr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) == 0, h, ma, ix, tg);
    end
  endtask

  task automatic test_reset_mid();
    logic h; logic [AW-1:0] ma; logic [IL-1:0] ix; logic [TL-1:0] tg;
    logic [AW-1:0] addr, refill;
    bit ok; int w;
    refill = last_fill_addr;
    do addr = $urandom;
    while (ref_valid[IL'((addr >> OL) % 256)] && ref_tag[IL'((addr >> OL) % 256)] == TL'(addr >> (OL + IL)));
    start_req(addr, ok);
    if (!ok) return;
    w = 0;
    while (mem_req_valid !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
    n_checks++;
    if (mem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_mreq: mem_req_valid=%b, required 1", mem_req_valid);
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({cpu_req_ready, mem_req_valid, tm_write, cpu_resp_valid} !== 4'b1000 ||
        hit_cnt !== '0 || miss_cnt !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ready/mv/tw/rv=%b hit %0d miss %0d, required 1000 0 0",
               {cpu_req_ready, mem_req_valid, tm_write, cpu_resp_valid}, hit_cnt, miss_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    n_checks++;
    if (tm_write !== 1'b0 || cpu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_resp: tm_write %b ready %b, required 0 1", tm_write, cpu_req_ready);
    end
    run_req(refill, 0, 1, 0, 0, h, ma, ix, tg);
    n_checks++;
    if (h !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_after_reset: hit %b, required 0", h);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_fill_addr = 32'h0000_1236;
    test_reset();
    test_miss_hit_conflict();
    test_flush_in_mwait();
    test_mem_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
